// File: rtl/gantry_pkg.sv
// Shared types and beam encodings for the car sensor emulator.
// Phase {a,b} values follow a Gray-style walk so only one beam toggles at a time.
package gantry_pkg;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        PH1  = 3'd1,
        PH2  = 3'd2,
        PH3  = 3'd3,
        GAP  = 3'd4
    } state_t;

    localparam logic DIR_ENTER = 1'b0;
    localparam logic DIR_EXIT  = 1'b1;

    localparam logic [1:0] AB_IDLE   = 2'b00;
    localparam logic [1:0] AB_GAP    = 2'b00;
    localparam logic [1:0] ENTER_PH1 = 2'b10;
    localparam logic [1:0] ENTER_PH2 = 2'b11;
    localparam logic [1:0] ENTER_PH3 = 2'b01;
    localparam logic [1:0] EXIT_PH1  = 2'b01;
    localparam logic [1:0] EXIT_PH2  = 2'b11;
    localparam logic [1:0] EXIT_PH3  = 2'b10;

    function automatic logic [1:0] phase_ab(input state_t s, input logic dir);
        logic [1:0] ab;
        ab = AB_IDLE;
        unique case (s)
            PH1:     ab = (dir == DIR_ENTER) ? ENTER_PH1 : EXIT_PH1;
            PH2:     ab = (dir == DIR_ENTER) ? ENTER_PH2 : EXIT_PH2;
            PH3:     ab = (dir == DIR_ENTER) ? ENTER_PH3 : EXIT_PH3;
            GAP:     ab = AB_GAP;
            default: ab = AB_IDLE;
        endcase
        return ab;
    endfunction

endpackage

// File: rtl/phase_timer.sv
// Per-phase down counter; reloads on load and flags the last cycle of a phase.
// Holds at zero instead of wrapping so a phase can never run long.
module phase_timer #(
    parameter int PHASE_CYCLES = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic load,
    output logic expire
);

    localparam logic [7:0] RELOAD = 8'(PHASE_CYCLES - 1);

    logic [7:0] count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= 8'd0;
        end else if (load) begin
            count <= RELOAD;
        end else if (count != 8'd0) begin
            count <= count - 8'd1;
        end
    end

    assign expire = (count == 8'd0);

endmodule

// File: rtl/car_sensor_emulator.sv
// Drives emulated outer/inner beam sensors through enter or exit sequences,
// with a one-entry pending buffer for requests that arrive while busy.
module car_sensor_emulator
    import gantry_pkg::*;
#(
    parameter int PHASE_CYCLES = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic req_enter,
    input  logic req_exit,
    output logic a,
    output logic b,
    output logic busy,
    output logic ready,
    output logic done_enter,
    output logic done_exit,
    output logic overflow
);

    state_t     state;
    state_t     nxt_state;
    logic       dir;
    logic       nxt_dir;
    logic       pend_valid;
    logic       nxt_pv;
    logic       pend_dir;
    logic       nxt_pd;
    logic [1:0] ab_q;
    logic       ovf_q;
    logic       drop;
    logic       load;
    logic       expire;
    logic       seq_end;
    logic       any;
    logic       both;
    logic       req_dir;

    phase_timer #(
        .PHASE_CYCLES(PHASE_CYCLES)
    ) u_timer (
        .clk    (clk),
        .rst_n  (rst_n),
        .load   (load),
        .expire (expire)
    );

    assign any     = req_enter | req_exit;
    assign both    = req_enter & req_exit;
    assign req_dir = req_enter ? DIR_ENTER : DIR_EXIT;
    assign busy    = (state != IDLE);
    assign seq_end = (state == GAP) && expire;

    always_comb begin
        nxt_state = state;
        nxt_dir   = dir;
        nxt_pv    = pend_valid;
        nxt_pd    = pend_dir;
        drop      = 1'b0;
        unique case (state)
            IDLE: begin
                if (any) begin
                    nxt_state = PH1;
                    nxt_dir   = req_dir;
                    nxt_pv    = both;
                    nxt_pd    = DIR_EXIT;
                end
            end
            PH1: if (expire) nxt_state = PH2;
            PH2: if (expire) nxt_state = PH3;
            PH3: if (expire) nxt_state = GAP;
            GAP: begin
                // Chain straight into the next sequence; a live request
                // with nothing pending passes through the buffer at once.
                if (expire) begin
                    if (pend_valid) begin
                        nxt_state = PH1;
                        nxt_dir   = pend_dir;
                        nxt_pv    = 1'b0;
                        drop      = any;
                    end else if (any) begin
                        nxt_state = PH1;
                        nxt_dir   = req_dir;
                        nxt_pv    = both;
                        nxt_pd    = DIR_EXIT;
                    end else begin
                        nxt_state = IDLE;
                    end
                end
            end
            default: nxt_state = IDLE;
        endcase
        if (busy && !seq_end && any) begin
            if (pend_valid) begin
                drop = 1'b1;
            end else begin
                nxt_pv = 1'b1;
                nxt_pd = req_dir;
                drop   = both;
            end
        end
    end

    assign load = (nxt_state != state);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            dir        <= DIR_ENTER;
            pend_valid <= 1'b0;
            pend_dir   <= DIR_ENTER;
            ab_q       <= AB_IDLE;
            ovf_q      <= 1'b0;
        end else begin
            state      <= nxt_state;
            dir        <= nxt_dir;
            pend_valid <= nxt_pv;
            pend_dir   <= nxt_pd;
            ab_q       <= phase_ab(nxt_state, nxt_dir);
            ovf_q      <= drop;
        end
    end

    assign a          = ab_q[1];
    assign b          = ab_q[0];
    assign ready      = ~pend_valid;
    assign done_enter = seq_end && (dir == DIR_ENTER);
    assign done_exit  = seq_end && (dir == DIR_EXIT);
    assign overflow   = ovf_q;

endmodule

// File: tb/tb_car_sensor_emulator.sv
// Bench for car_sensor_emulator: directed scenarios with literal expectations
// plus randomized traffic checked every cycle against a timeline model.
module tb_car_sensor_emulator;

    localparam int PC  = 2;
    localparam int SEQ = 4 * PC;

    logic clk;
    logic rst_n;
    logic req_enter;
    logic req_exit;
    logic a;
    logic b;
    logic busy;
    logic ready;
    logic done_enter;
    logic done_exit;
    logic overflow;

    car_sensor_emulator #(
        .PHASE_CYCLES(PC)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_enter  (req_enter),
        .req_exit   (req_exit),
        .a          (a),
        .b          (b),
        .busy       (busy),
        .ready      (ready),
        .done_enter (done_enter),
        .done_exit  (done_exit),
        .overflow   (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;
    int cars = 0;
    logic [6:0] lg [0:63];
    logic [1:0] prev_ab = 2'b00;

    // Model: an active sequence is a direction plus elapsed cycle count.
    bit m_act = 0;
    bit m_dir = 0;
    int m_t = 0;
    bit m_pv = 0;
    bit m_pd = 0;
    bit m_ov = 0;

    function automatic void chk(input string nm, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s cyc=%0d got=%0h expected=%0h", nm, cyc, act, exp);
        end
    endfunction

    function automatic logic [6:0] dut_vec();
        return {a, b, busy, ready, done_enter, done_exit, overflow};
    endfunction

    function automatic logic [6:0] mdl_vec();
        logic [1:0] ab;
        int ph;
        ab = 2'b00;
        if (m_act) begin
            ph = m_t / PC;
            case (ph)
                0:       ab = m_dir ? 2'b01 : 2'b10;
                1:       ab = 2'b11;
                2:       ab = m_dir ? 2'b10 : 2'b01;
                default: ab = 2'b00;
            endcase
        end
        return {ab, m_act, !m_pv,
                m_act && (m_t == SEQ - 1) && !m_dir,
                m_act && (m_t == SEQ - 1) && m_dir,
                m_ov};
    endfunction

    task automatic m_start(input bit d);
        m_act = 1;
        m_dir = d;
        m_t = 0;
    endtask

    task automatic model_reset();
        m_act = 0;
        m_dir = 0;
        m_t = 0;
        m_pv = 0;
        m_pd = 0;
        m_ov = 0;
    endtask

    task automatic model_step();
        bit e;
        bit x;
        bit ov;
        e = req_enter;
        x = req_exit;
        ov = 0;
        if (!m_act) begin
            if (e || x) begin
                m_start(e ? 1'b0 : 1'b1);
                if (e && x) begin
                    m_pv = 1;
                    m_pd = 1;
                end
            end
        end else if (m_t == SEQ - 1) begin
            if (m_pv) begin
                m_start(m_pd);
                m_pv = 0;
                ov = e || x;
            end else if (e || x) begin
                m_start(e ? 1'b0 : 1'b1);
                if (e && x) begin
                    m_pv = 1;
                    m_pd = 1;
                end
            end else begin
                m_act = 0;
            end
        end else begin
            m_t++;
            if (e || x) begin
                if (m_pv) begin
                    ov = 1;
                end else begin
                    m_pv = 1;
                    m_pd = e ? 1'b0 : 1'b1;
                    ov = e && x;
                end
            end
        end
        m_ov = ov;
    endtask

    task automatic tick(input logic e, input logic x);
        logic [6:0] v;
        @(negedge clk);
        v = dut_vec();
        chk("cycle", int'(v), int'(mdl_vec()));
        chk("gray", int'((prev_ab ^ v[6:5]) == 2'b11), 0);
        prev_ab = v[6:5];
        if (cyc < 64) lg[cyc] = v;
        cyc++;
        if (v[2]) cars++;
        if (v[1]) cars--;
        req_enter = e;
        req_exit = x;
        @(posedge clk);
        model_step();
    endtask

    task automatic do_reset();
        @(negedge clk);
        #1;
        rst_n = 1'b0;
        req_enter = 1'b0;
        req_exit = 1'b0;
        model_reset();
        #1;
        chk("reset_state", int'(dut_vec()), int'(7'b0001000));
        #2;
        rst_n = 1'b1;
        prev_ab = 2'b00;
        @(posedge clk);
        model_step();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick(1'b0, 1'b0);
    endtask

    initial begin
        int dones;
        rst_n = 1'b0;
        req_enter = 1'b0;
        req_exit = 1'b0;
        do_reset();

        // Single enter
        cyc = 0;
        tick(1'b1, 1'b0);
        idle(11);
        chk("enter_ph1_c1", int'(lg[1][6:5]), 2);
        chk("enter_ph1_c2", int'(lg[2][6:5]), 2);
        chk("enter_ph2_c3", int'(lg[3][6:5]), 3);
        chk("enter_ph3_c5", int'(lg[5][6:5]), 1);
        chk("enter_gap_c7", int'(lg[7][6:5]), 0);
        chk("enter_done_c7", int'(lg[7][2]), 0);
        chk("enter_done_c8", int'(lg[8][2]), 1);
        chk("enter_busy_c8", int'(lg[8][4]), 1);
        chk("enter_busy_c9", int'(lg[9][4]), 0);

        // Single exit
        do_reset();
        cyc = 0;
        tick(1'b0, 1'b1);
        idle(11);
        chk("exit_ph1_c1", int'(lg[1][6:5]), 1);
        chk("exit_ph2_c4", int'(lg[4][6:5]), 3);
        chk("exit_ph3_c6", int'(lg[6][6:5]), 2);
        chk("exit_done_c8", int'(lg[8][1]), 1);
        dones = 0;
        for (int i = 0; i < 12; i++) dones += int'(lg[i][2]);
        chk("exit_no_enter_done", dones, 0);

        // Both at once: enter runs, exit buffered
        do_reset();
        cyc = 0;
        tick(1'b1, 1'b1);
        idle(19);
        for (int i = 1; i <= 8; i++) chk("both_ready_low", int'(lg[i][3]), 0);
        chk("both_ready_c9", int'(lg[9][3]), 1);
        chk("both_done_enter_c8", int'(lg[8][2]), 1);
        chk("both_exit_ph1_c9", int'(lg[9][6:5]), 1);
        chk("both_done_exit_c16", int'(lg[16][1]), 1);

        // Three enters: second buffered, third dropped
        do_reset();
        cyc = 0;
        tick(1'b1, 1'b0);
        tick(1'b0, 1'b0);
        tick(1'b1, 1'b0);
        tick(1'b0, 1'b0);
        tick(1'b1, 1'b0);
        idle(20);
        chk("triple_ovf_c5", int'(lg[5][0]), 1);
        dones = 0;
        for (int i = 0; i < 25; i++) dones += int'(lg[i][2]) + int'(lg[i][1]);
        chk("triple_two_dones", dones, 2);

        // Reset mid-sequence, then a clean exit
        do_reset();
        cyc = 0;
        tick(1'b1, 1'b0);
        idle(3);
        do_reset();
        cyc = 0;
        tick(1'b0, 1'b1);
        idle(11);
        chk("post_rst_exit_ph1", int'(lg[1][6:5]), 1);
        chk("post_rst_done_exit", int'(lg[8][1]), 1);

        // Car count loopback: 3 enters then 1 exit
        do_reset();
        cars = 0;
        tick(1'b1, 1'b0);
        idle(10);
        tick(1'b1, 1'b0);
        idle(10);
        tick(1'b1, 1'b0);
        idle(10);
        tick(1'b0, 1'b1);
        idle(10);
        chk("car_count", cars, 2);

        // Randomized traffic with occasional asynchronous resets
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 199) == 0) begin
                do_reset();
            end else begin
                tick(logic'($urandom_range(0, 4) == 0),
                     logic'($urandom_range(0, 5) == 0));
            end
        end
        idle(20);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/car_sensor_emulator.md
CAR_SENSOR_EMULATOR -- requirements
Module: car_sensor_emulator

Interface
REQ-001 Parameter PHASE_CYCLES, default 4, SHALL set the number of clock cycles each sensor phase is held; legal range 1..255.
REQ-002 clk  input  1  SHALL be the single clock; all state changes occur on its rising edge.
REQ-003 rst_n  input  1  SHALL be the reset; it is asynchronous and active-low.
REQ-004 req_enter  input  1  SHALL be a one-cycle request to emulate one car entering.
REQ-005 req_exit  input  1  SHALL be a one-cycle request to emulate one car exiting.
REQ-006 a  output  1  SHALL be the emulated outer beam sensor (1 = blocked), registered.
REQ-007 b  output  1  SHALL be the emulated inner beam sensor (1 = blocked), registered.
REQ-008 busy  output  1  SHALL be high whenever a sequence is in progress.
REQ-009 ready  output  1  SHALL be high when the one-entry pending buffer is empty.
REQ-010 done_enter  output  1  SHALL pulse one cycle at the end of an enter sequence.
REQ-011 done_exit  output  1  SHALL pulse one cycle at the end of an exit sequence.
REQ-012 overflow  output  1  SHALL pulse one cycle when a request is dropped.

Function
REQ-013 States SHALL be IDLE, PH1, PH2, PH3, GAP; each non-IDLE state lasts exactly PHASE_CYCLES cycles.
REQ-014 Enter sequence {a,b}: PH1=10, PH2=11, PH3=01, GAP=00; exit sequence: PH1=01, PH2=11, PH3=10, GAP=00; IDLE=00.
REQ-015 A request sampled in IDLE at edge k SHALL drive the PH1 value on a/b from edge k+1 (one-cycle latency).
REQ-016 done_enter/done_exit SHALL assert during the last GAP cycle; busy SHALL be high from PH1 through the last GAP cycle.
REQ-017 On leaving GAP, a valid pending entry SHALL start its PH1 on the next edge with no IDLE cycle; otherwise go to IDLE.
REQ-018 Request while busy and buffer empty: stored in buffer, ready falls next cycle.
REQ-019 Request while buffer full (including the cycle GAP ends): dropped, overflow pulses next cycle.
REQ-020 req_enter and req_exit together in IDLE with empty buffer: enter starts, exit buffered.
REQ-021 Both together while busy with empty buffer: enter buffered, exit dropped with overflow.
REQ-022 Both together while buffer full: both dropped, one overflow pulse.
REQ-023 Phase counter SHALL be 8 bits, reload on every state change, never wrap within a phase.
REQ-024 a and b SHALL never change simultaneously except at 00<->11, which never occurs (Gray-style sequence).

Reset
REQ-025 rst_n low SHALL immediately force IDLE, a=b=0, busy=0, ready=1, done_enter=done_exit=overflow=0, buffer empty, counter 0.
REQ-026 Reset mid-sequence SHALL abort without any done pulse; first request after release obeys REQ-015.

Structure
REQ-027 Shared package gantry_pkg SHALL hold the state enum, direction constants (DIR_ENTER, DIR_EXIT) and the per-phase {a,b} encodings.
REQ-028 One sub-module, phase_timer (load, PHASE_CYCLES, expire pulse), SHALL hold the phase counter.

Verification (PHASE_CYCLES=2)
REQ-029 req_enter at cycle 0 -> ab=10 cycles 1-2, 11 cycles 3-4, 01 cycles 5-6, 00 cycles 7-8, done_enter at cycle 8, busy low cycle 9.
REQ-030 req_exit at cycle 0 -> ab=01,11,10,00 per two cycles, done_exit at cycle 8, no done_enter.
REQ-031 req_enter and req_exit at cycle 0 -> enter sequence, ready=0 cycles 1-8, exit PH1 (ab=01) at cycle 9, done_exit at cycle 16.
REQ-032 req_enter at cycles 0, 2, 4 -> second buffered, third dropped with overflow at cycle 5, exactly two done pulses.
REQ-033 rst_n low at cycle 4 of an enter sequence -> ab=00, busy=0 immediately, no done pulse; req_exit after release gives full exit sequence.
REQ-034 Loopback into the existing parking FSM and counter: 3 enters then 1 exit -> car count 2.
